usb_audio_ep_dma: RTL

- Wishbone master on the system clock. Drains isochronous OUT audio payload from the USB endpoint buffer and presents it as a 32-bit sample stream, e.g. to the audio PCM FIFO.
- Directly downstream of the USB SoC wrapper: consumes its system-domain SoF strobe and drives its EP-buffer Wishbone port (single-cycle ack, one ack per cycle).
- Per SoF, fetches the active bank of the ping-pong EP buffer word by word.

---
 rtl/usb_audio_ep_dma_pkg.sv | 16 +
 rtl/usb_audio_ep_dma_fsm.sv | 89 ++++++++
 rtl/usb_audio_ep_dma.sv | 86 ++++++++
 3 files changed

// File: rtl/usb_audio_ep_dma_pkg.sv
// Shared definitions for the USB audio endpoint DMA.
//   dma_state_e   : frame engine states
//   EP_BANK_WORDS : words per ping-pong bank, also the longest legal frame
//   OVR_MAX       : saturation value of the dropped-SoF counter
package usb_audio_ep_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PUSH = 2'd2
  } dma_state_e;

  localparam int unsigned EP_BANK_WORDS = 256;
  localparam logic [7:0]  OVR_MAX       = 8'hff;

endpackage

// File: rtl/usb_audio_ep_dma_fsm.sv
// Frame engine: walks one EP-buffer bank word by word.
//   start     : accepted SoF (only asserted while idle)
//   cfg_len   : requested length, clipped to one bank and latched on start
//   wb_ack    : read acknowledge for the outstanding request
//   out_ready : downstream accepted the presented word
//   busy/req/push : state decodes (frame active, bus request, stream valid)
//   cap       : capture strobe for the read data register
//   idx_lo    : word offset inside the bank
module usb_audio_ep_dma_fsm
  import usb_audio_ep_dma_pkg::*;
#(
  parameter int AW = 9,
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] cfg_len,
  input  logic          wb_ack,
  input  logic          out_ready,
  output logic          busy,
  output logic          req,
  output logic          push,
  output logic          cap,
  output logic [AW-2:0] idx_lo
);

  // One bit wider than the in-bank offset so a full 256-word frame
  // terminates on idx+1 == len instead of wrapping.
  localparam int CW = AW;

  dma_state_e    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] len_clip;
  logic [CW-1:0] idx_inc;

  always_comb begin
    len_clip = (32'(cfg_len) > EP_BANK_WORDS) ? CW'(EP_BANK_WORDS) : CW'(cfg_len);
    idx_inc  = idx_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d = len_clip;
          idx_d = '0;
          // zero-length frame only consumes the bank toggle
          if (len_clip != '0) state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wb_ack) state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (out_ready) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? ST_IDLE : ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  // Outputs decode straight from the state flop so async reset drops
  // wb_cyc / out_valid immediately.
  assign busy   = (state_q != ST_IDLE);
  assign req    = (state_q == ST_REQ);
  assign push   = (state_q == ST_PUSH);
  assign cap    = req & wb_ack;
  assign idx_lo = idx_q[AW-2:0];

endmodule

// File: rtl/usb_audio_ep_dma.sv
// USB audio isochronous OUT endpoint DMA.
// Per accepted SoF, reads the active ping-pong bank of the EP buffer over
// Wishbone (one outstanding single-word read) and forwards each word on a
// valid/ready sample stream.
//   clk, rst_n          : system clock, async active-low reset
//   sof, cfg_len, cfg_en: frame strobe, frame length, engine enable
//   wb_*                : EP buffer Wishbone master (read only)
//   out_*               : 32-bit sample stream (L in [31:16], R in [15:0])
//   busy, bank, ovr_cnt : frame active, bank of last frame, dropped SoFs
module usb_audio_ep_dma
  import usb_audio_ep_dma_pkg::*;
#(
  parameter int AW = 9,
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sof,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_en,
  output logic [AW-1:0] wb_addr,
  output logic          wb_cyc,
  output logic          wb_we,
  input  logic [31:0]   wb_rdata,
  input  logic          wb_ack,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          bank,
  output logic [7:0]    ovr_cnt
);

  logic          accept, drop;
  logic          req, push, cap;
  logic [AW-2:0] idx_lo;
  logic          bank_q, bank_d;
  logic [7:0]    ovr_q, ovr_d;
  logic [31:0]   data_q, data_d;

  // busy covers REQ and PUSH; a SoF in either is a collision.
  assign accept = sof & cfg_en & ~busy;
  assign drop   = sof & cfg_en & busy;

  usb_audio_ep_dma_fsm #(.AW(AW), .LW(LW)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .cfg_len   (cfg_len),
    .wb_ack    (wb_ack),
    .out_ready (out_ready),
    .busy      (busy),
    .req       (req),
    .push      (push),
    .cap       (cap),
    .idx_lo    (idx_lo)
  );

  always_comb begin
    bank_d = accept ? ~bank_q : bank_q;
    ovr_d  = (drop && (ovr_q != OVR_MAX)) ? ovr_q + 8'd1 : ovr_q;
    data_d = cap ? wb_rdata : data_q;
  end

  // bank resets to 1 so the first accepted frame lands in bank 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= 1'b1;
      ovr_q  <= '0;
      data_q <= '0;
    end else begin
      bank_q <= bank_d;
      ovr_q  <= ovr_d;
      data_q <= data_d;
    end
  end

  assign wb_cyc    = req;
  assign wb_we     = 1'b0;
  assign wb_addr   = req ? {bank_q, idx_lo} : '0;
  assign out_valid = push;
  assign out_data  = data_q;
  assign bank      = bank_q;
  assign ovr_cnt   = ovr_q;

endmodule
